// File: rtl/multicycle_sequencer_pkg.sv
// Shared types for the multicycle sequencer: FSM states, instruction
// classes, condition codes, NZCV bit positions and the strobe bundle.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_DP,
        CLS_LS,
        CLS_BR,
        CLS_NOP,
        CLS_HALT
    } cls_e;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic ir_we;
        logic pc_we;
        logic rf_we;
        logic flags_we;
        logic dmem_we;
        logic dmem_re;
        logic sel_x;
        logic halted;
    } strobe_t;

    localparam strobe_t STR_FETCH = '{ir_we: 1'b1, default: 1'b0};

    // op is instruction[27:24]
    function automatic cls_e decode_cls(input logic [3:0] op);
        cls_e c;
        c = CLS_NOP;
        unique case (1'b1)
            (op == 4'hF):       c = CLS_HALT;
            (op[3:2] == 2'b00): c = CLS_DP;
            (op[3:2] == 2'b01): c = CLS_LS;
            (op[3:2] == 2'b10): c = CLS_BR;
            default:            c = CLS_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_cond_check.sv
// Combinational condition-code evaluator: 16 standard codes against NZCV,
// with 1111 meaning never.
module cond_check
    import multicycle_sequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_EQ:   pass = z;
            CC_NE:   pass = !z;
            CC_CS:   pass = c;
            CC_CC:   pass = !c;
            CC_MI:   pass = n;
            CC_PL:   pass = !n;
            CC_VS:   pass = v;
            CC_VC:   pass = !v;
            CC_HI:   pass = c && !z;
            CC_LS:   pass = !c || z;
            CC_GE:   pass = (n == v);
            CC_LT:   pass = (n != v);
            CC_GT:   pass = !z && (n == v);
            CC_LE:   pass = z || (n != v);
            CC_AL:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM driving datapath strobes.
// Define SEQ_PERF_CNT_EN to build the retired/cycle performance counters.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic [3:0]       flags,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             flags_we,
    output logic             dmem_we,
    output logic             dmem_re,
    output logic             select_X,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_e  state_q, state_d;
    cls_e    cls_q, cls_d;
    logic    b20_q, b20_d;
    strobe_t str_q, str_d;
    cls_e    dec_cls;
    logic    cond_pass;
    logic    store_done;
    logic    unused_insn;

    assign unused_insn = ^instruction[19:0];
    assign dec_cls     = decode_cls(instruction[27:24]);

    cond_check u_cond (
        .cond (instruction[31:28]),
        .nzcv (flags),
        .pass (cond_pass)
    );

    // b20 is the load bit for load/store and the S bit for data-processing
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        b20_d   = b20_q;
        unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                b20_d = instruction[20];
                if (dec_cls == CLS_HALT) begin
                    cls_d   = CLS_HALT;
                    state_d = S_HALT;
                end else begin
                    cls_d   = cond_pass ? dec_cls : CLS_NOP;
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                unique case (cls_q)
                    CLS_DP:  state_d = S_WRITEBACK;
                    CLS_LS:  state_d = S_MEMORY;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMORY: begin
                if (dmem_ready)
                    state_d = b20_q ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    // strobes are registered for the state being entered
    always_comb begin
        str_d = '0;
        unique case (state_d)
            S_FETCH:   str_d.ir_we = 1'b1;
            S_EXECUTE: str_d.pc_we = (cls_d != CLS_DP) && (cls_d != CLS_LS);
            S_MEMORY: begin
                str_d.dmem_re = b20_d;
                str_d.dmem_we = !b20_d;
            end
            S_WRITEBACK: begin
                str_d.rf_we    = 1'b1;
                str_d.pc_we    = 1'b1;
                str_d.flags_we = (cls_d == CLS_DP) && b20_d;
                str_d.sel_x    = (cls_d == CLS_LS);
            end
            S_HALT:  str_d.halted = 1'b1;
            default: str_d = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_NOP;
            b20_q   <= 1'b0;
            str_q   <= STR_FETCH;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            b20_q   <= b20_d;
            str_q   <= str_d;
        end
    end

    // a store retires in the same cycle memory completes
    assign store_done = (state_q == S_MEMORY) && !b20_q && dmem_ready;

    assign ir_we    = str_q.ir_we    && !reset;
    assign pc_we    = (str_q.pc_we || store_done) && !reset;
    assign rf_we    = str_q.rf_we    && !reset;
    assign flags_we = str_q.flags_we && !reset;
    assign dmem_we  = str_q.dmem_we  && !reset;
    assign dmem_re  = str_q.dmem_re  && !reset;
    assign select_X = str_q.sel_x    && !reset;
    assign halted   = str_q.halted   && !reset;
    assign state    = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] ret_q, cyc_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ret_q <= '0;
            cyc_q <= '0;
        end else begin
            if (state_q != S_HALT)
                cyc_q <= cyc_q + 1'b1;
            if (pc_we)
                ret_q <= ret_q + 1'b1;
        end
    end

    assign retired_cnt = reset ? '0 : ret_q;
    assign cycle_cnt   = reset ? '0 : cyc_q;
`else
    assign retired_cnt = '0;
    assign cycle_cnt   = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: per-cycle expectations are
// queued by the stimulus and checked by an independent monitor.
module tb_multicycle_sequencer;

    localparam int CNT_W = 4;

    localparam logic [7:0] NONE = 8'h00;
    localparam logic [7:0] IR   = 8'h80;
    localparam logic [7:0] PC   = 8'h40;
    localparam logic [7:0] RF   = 8'h20;
    localparam logic [7:0] FL   = 8'h10;
    localparam logic [7:0] DWE  = 8'h08;
    localparam logic [7:0] DRE  = 8'h04;
    localparam logic [7:0] SEL  = 8'h02;
    localparam logic [7:0] HLT  = 8'h01;

    logic             clk;
    logic             reset;
    logic [31:0]      instruction;
    logic [3:0]       flags;
    logic             dmem_ready;
    logic             ir_we, pc_we, rf_we, flags_we;
    logic             dmem_we, dmem_re, select_X, halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired_cnt, cycle_cnt;

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .instruction (instruction),
        .flags       (flags),
        .dmem_ready  (dmem_ready),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .rf_we       (rf_we),
        .flags_we    (flags_we),
        .dmem_we     (dmem_we),
        .dmem_re     (dmem_re),
        .select_X    (select_X),
        .state       (state),
        .halted      (halted),
        .retired_cnt (retired_cnt),
        .cycle_cnt   (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            nm;
        logic [2:0]       st;
        logic [7:0]       sb;
        logic [CNT_W-1:0] cyc;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t             sb_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] cyc_acc = '0;
    logic [CNT_W-1:0] ret_acc = '0;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = sb_q.pop_front();
            act = {ir_we, pc_we, rf_we, flags_we,
                   dmem_we, dmem_re, select_X, halted};
            n_cmp++;
            if (state !== e.st) begin
                n_bad++;
                $display("FAIL %s state: got %0d want %0d",
                         e.nm, state, e.st);
            end
            n_cmp++;
            if (act !== e.sb) begin
                n_bad++;
                $display("FAIL %s strobes: got %b want %b",
                         e.nm, act, e.sb);
            end
            n_cmp++;
            if (cycle_cnt !== e.cyc || retired_cnt !== e.ret) begin
                n_bad++;
                $display("FAIL %s counters: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         e.nm, cycle_cnt, retired_cnt, e.cyc, e.ret);
            end
        end
    end

    task automatic step(input string nm, input logic [2:0] st,
                        input logic [7:0] sbv);
        exp_t e;
        logic rst_now;
        rst_now = reset;
        e.nm  = nm;
        e.st  = st;
        e.sb  = sbv;
        e.cyc = rst_now ? '0 : cyc_acc;
        e.ret = rst_now ? '0 : ret_acc;
`ifndef SEQ_PERF_CNT_EN
        e.cyc = '0;
        e.ret = '0;
`endif
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst_now) begin
            cyc_acc = '0;
            ret_acc = '0;
        end else begin
            if (st != 3'd7)
                cyc_acc = cyc_acc + 1'b1;
            if (sbv[6])
                ret_acc = ret_acc + 1'b1;
        end
    endtask

    task automatic short_insn(input string nm, input logic [31:0] insn);
        instruction = insn;
        step({nm, "_f"}, 3'd0, IR);
        step({nm, "_d"}, 3'd1, NONE);
        step({nm, "_e"}, 3'd2, PC);
    endtask

    initial begin
        reset       = 1'b1;
        instruction = 32'h0;
        flags       = 4'b0000;
        dmem_ready  = 1'b0;
        @(posedge clk);
        #1;
        step("rst0", 3'd0, NONE);
        step("rst1", 3'd0, NONE);
        reset = 1'b0;

        instruction = 32'hE0912003;
        dmem_ready  = 1'b1;
        step("adds_f",  3'd0, IR);
        step("adds_d",  3'd1, NONE);
        step("adds_e",  3'd2, NONE);
        step("adds_wb", 3'd4, RF | PC | FL);

        instruction = 32'hE0812003;
        step("add_f",  3'd0, IR);
        step("add_d",  3'd1, NONE);
        step("add_e",  3'd2, NONE);
        step("add_wb", 3'd4, RF | PC);

        instruction = 32'hE5912000;
        dmem_ready  = 1'b0;
        step("ldr_f",  3'd0, IR);
        step("ldr_d",  3'd1, NONE);
        step("ldr_e",  3'd2, NONE);
        step("ldr_m0", 3'd3, DRE);
        step("ldr_m1", 3'd3, DRE);
        dmem_ready = 1'b1;
        step("ldr_m2", 3'd3, DRE);
        dmem_ready = 1'b0;
        step("ldr_wb", 3'd4, RF | PC | SEL);

        flags = 4'b0100;
        short_insn("bne", 32'h1A000002);
        short_insn("beq", 32'h0A000002);
        flags = 4'b0000;
        short_insn("eqfail", 32'h00912003);
        dmem_ready = 1'b1;
        short_insn("nop", 32'hEC000000);
        short_insn("never", 32'hF0912003);

        instruction = 32'hE5812000;
        step("str_f", 3'd0, IR);
        step("str_d", 3'd1, NONE);
        step("str_e", 3'd2, NONE);
        step("str_m", 3'd3, DWE | PC);

        dmem_ready = 1'b0;
        step("strw_f",  3'd0, IR);
        step("strw_d",  3'd1, NONE);
        step("strw_e",  3'd2, NONE);
        step("strw_m0", 3'd3, DWE);
        reset = 1'b1;
        step("strw_rst", 3'd3, NONE);
        reset = 1'b0;
        step("strw_post", 3'd0, IR);

        instruction = 32'hEF000000;
        step("hlt_d", 3'd1, NONE);
        for (int i = 0; i < 20; i++) begin
            dmem_ready = i[0];
            step("hlt_hold", 3'd7, HLT);
        end
        dmem_ready = 1'b0;
        reset = 1'b1;
        step("hlt_rst", 3'd7, NONE);
        reset = 1'b0;

        for (int i = 0; i < 17; i++)
            short_insn("wrap", 32'hEC000000);
        step("wrap_end", 3'd0, IR);

        for (int i = 0; i < 5 && sb_q.size() > 0; i++)
            @(posedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter CNT_W, default 16: width of the performance counters.
REQ-002 CLOCK_50  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 instruction  in  32  current instruction word, stable from DECODE to end of instruction.
REQ-005 flags  in  4  NZCV from the flags register.
REQ-006 dmem_ready  in  1  data-memory completion handshake.
REQ-007 ir_we, pc_we, rf_we, flags_we, dmem_we, dmem_re  out  1 each  datapath strobes.
REQ-008 select_X  out  1  writeback source: 0 = ALU, 1 = DMEM.
REQ-009 state  out  3  current FSM state encoding.
REQ-010 halted  out  1  high while in HALT.
REQ-011 retired_cnt, cycle_cnt  out  CNT_W each  performance counters.

Function
REQ-012 States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=7; no other encodings are reachable.
REQ-013 Class decode from instruction[27:26]: 00 = data-processing, 01 = load/store (bit 20 = 1 load, 0 store), 10 = branch; instruction[27:24]=1111 = halt; class 11 otherwise = no-op.
REQ-014 Condition in instruction[31:28] evaluated in DECODE against flags using the 16 standard codes (EQ..AL), with 1111 = never.
REQ-015 FETCH: ir_we=1 for one cycle -> DECODE.
REQ-016 DECODE: halt class -> HALT. Condition false or no-op -> EXECUTE with all write strobes suppressed. Otherwise -> EXECUTE.
REQ-017 EXECUTE: data-processing -> WRITEBACK. Load/store -> MEMORY. Branch, no-op or failed condition -> pc_we=1, then FETCH.
REQ-018 Data-processing writes rf_we=1 and pc_we=1 in WRITEBACK; flags_we=1 in WRITEBACK only if S bit instruction[20]=1.
REQ-019 MEMORY: dmem_re (load) or dmem_we (store) held high until the cycle dmem_ready=1, inclusive. Store then pc_we=1 in that cycle -> FETCH. Load -> WRITEBACK.
REQ-020 Load WRITEBACK: select_X=1, rf_we=1, pc_we=1; select_X=0 in all other states.
REQ-021 Latency with zero-wait memory: data-processing 4 cycles, load 5, store 4, branch, failed condition and no-op 3.
REQ-022 Each strobe is at most one cycle per instruction, except dmem_re/dmem_we during wait.
REQ-023 dmem_ready outside MEMORY is ignored.
REQ-024 HALT is absorbing: no strobes asserted; only reset exits.

Reset
REQ-025 Reset at any cycle, including mid-MEMORY wait, forces FETCH next cycle.
REQ-026 During reset and the following edge, all strobes and select_X = 0, halted=0, counters=0.
REQ-027 Reset has priority over every transition.

Configuration
REQ-028 With SEQ_PERF_CNT_EN defined: cycle_cnt increments every non-reset cycle outside HALT, and retired_cnt increments on each pc_we. Both wrap modulo 2^CNT_W.
REQ-029 Without SEQ_PERF_CNT_EN: both counters are constant 0 and no counter flops are synthesized.

Structure
REQ-030 Shared package holds the state enum, the instruction-class enum, condition-code constants and the NZCV bit indices.
REQ-031 Sub-module cond_check, combinational (cond[3:0], nzcv[3:0]) -> pass, instantiated once.

Verification
REQ-032 instruction=E0912003 (ADDS, AL), dmem_ready=1 -> states 0,1,2,4. In WRITEBACK: rf_we=pc_we=flags_we=1.
REQ-033 LDR E5912000, dmem_ready low 2 cycles then high -> MEMORY lasts 3 cycles with dmem_re=1, then WRITEBACK with select_X=1, rf_we=1; total 7 cycles.
REQ-034 flags=0100 (Z), instruction=1A000002 (BNE) -> 3 cycles, pc_we=1 in EXECUTE, rf_we=flags_we=0 throughout.
REQ-035 instruction=EF000000 -> HALT after DECODE, halted=1. Holding 20 cycles shows no strobes and cycle_cnt frozen. reset=1 -> FETCH, counters 0.
REQ-036 STR with dmem_ready low, reset asserted in second MEMORY cycle -> dmem_we=0 on the next edge and FETCH follows.
REQ-037 SEQ_PERF_CNT_EN, CNT_W=4, 17 no-op instructions -> retired_cnt wraps to 1.
